// File: rtl/alpha_sched.sv
// Forward-recursion scheduler: sequences LOAD/COMP/UPD/WR per trellis step for the alpha unit.
// Optional LOAD stall counter enabled by defining ALPHA_SCHED_STALL_CNT_EN.
module alpha_sched #(
  parameter int DW    = 16,
  parameter int KW    = 13,
  parameter int TAIL  = 3,
  parameter int MAX_K = 6144
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [KW-1:0] blk_len,
  input  logic          br_valid,
  output logic          br_ready,
  input  logic [DW-1:0] br_gamma1,
  input  logic [DW-1:0] br_gamma2,
  output logic          valid_branch,
  output logic [DW-1:0] init_branch1,
  output logic [DW-1:0] init_branch2,
  output logic          alpha_wr_en,
  output logic [KW-1:0] alpha_wr_addr,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [15:0]   stall_cnt
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] LOAD = 3'd1;
  localparam logic [2:0] COMP = 3'd2;
  localparam logic [2:0] UPD  = 3'd3;
  localparam logic [2:0] WR   = 3'd4;
  localparam logic [2:0] DONE = 3'd5;

  localparam logic [KW:0] MAX_LEN = (KW+1)'(MAX_K);
  localparam logic [KW:0] TAIL_W  = (KW+1)'(TAIL);

  logic [2:0]    state;
  logic [KW-1:0] step;
  logic [KW-1:0] len;
  logic          len_bad;
  logic          more_steps;
  logic          step_is_data;

  assign len_bad      = (blk_len == '0) || ({1'b0, blk_len} > MAX_LEN);
  // One extra bit keeps len+TAIL from wrapping near the top of the KW range.
  assign more_steps   = ({1'b0, step} + (KW+1)'(1)) < ({1'b0, len} + TAIL_W);
  assign step_is_data = step < len;

  // Outputs are registered alongside the state so each strobe lines up with its state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      step          <= '0;
      len           <= '0;
      br_ready      <= 1'b0;
      valid_branch  <= 1'b0;
      init_branch1  <= '0;
      init_branch2  <= '0;
      alpha_wr_en   <= 1'b0;
      alpha_wr_addr <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
    end else begin
      valid_branch <= 1'b0;
      alpha_wr_en  <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            len  <= blk_len;
            step <= '0;
            busy <= 1'b1;
            if (len_bad) begin
              state <= DONE;
              done  <= 1'b1;
              err   <= 1'b1;
            end else begin
              state    <= LOAD;
              br_ready <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (br_valid) begin
            init_branch1 <= br_gamma1;
            init_branch2 <= br_gamma2;
            br_ready     <= 1'b0;
            valid_branch <= 1'b1;
            state        <= COMP;
          end
        end
        COMP: state <= UPD;
        UPD: begin
          state <= WR;
          // Termination steps run the recursion but leave the alpha store untouched.
          if (step_is_data) begin
            alpha_wr_en   <= 1'b1;
            alpha_wr_addr <= step;
          end
        end
        WR: begin
          step <= step + KW'(1);
          if (more_steps) begin
            state    <= LOAD;
            br_ready <= 1'b1;
          end else begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          busy     <= 1'b0;
          br_ready <= 1'b0;
        end
      endcase
    end
  end

`ifdef ALPHA_SCHED_STALL_CNT_EN
  // Counts LOAD cycles spent waiting on branch metrics, saturating rather than wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_cnt <= '0;
    else if (state == IDLE && start)
      stall_cnt <= '0;
    else if (state == LOAD && !br_valid && stall_cnt != 16'hFFFF)
      stall_cnt <= stall_cnt + 16'd1;
  end
`else
  assign stall_cnt = '0;
`endif

endmodule
